count_macro_checker: RTL and testbench

COUNT_MACRO_CHECKER -- requirements
Module: count_macro_checker

---
 rtl/count_macro_checker_pkg.sv | 22 ++
 rtl/count_macro_checker_sync2.sv | 24 ++
 rtl/count_macro_checker.sv | 138 +++++++++++++
 tb/tb_count_macro_checker.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/count_macro_checker_pkg.sv
// Shared types and widths for the counter-macro checker.
package count_macro_checker_pkg;

  localparam int COUNT_W = 4;   // counter macro output width
  localparam int ERR_W   = 8;   // saturating mismatch counter width
  localparam int PULSE_W = 16;  // pulse count / sample index width

  typedef enum logic [2:0] {
    IDLE,
    RESET,
    ZERO_CHK,
    HIGH,
    LOW,
    DONE
  } state_t;

  // Increment that sticks at the all-ones value.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == {ERR_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/count_macro_checker_sync2.sv
// Parameterised-width two-flop synchronizer for signals crossing into clk.
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // Two back-to-back flops; only q is used downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/count_macro_checker.sv
// Drives clock/reset into an external 4-bit counter macro and checks its
// count after reset and after every macro clock pulse.
module count_macro_checker
  import count_macro_checker_pkg::*;
#(
  parameter int HALF_PERIOD  = 4,
  parameter int RESET_CYCLES = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [PULSE_W-1:0] num_pulses,
  input  logic [COUNT_W-1:0] count_in,
  output logic               macro_clk,
  output logic               macro_reset_n,
  output logic               busy,
  output logic               done,
  output logic [PULSE_W-1:0] pulses_sent,
  output logic [ERR_W-1:0]   err_count,
  output logic               err_flag,
  output logic [PULSE_W-1:0] first_err_idx
);

  // Timer must cover the longer of the two phase lengths.
  localparam int TMR_MAX = (HALF_PERIOD > RESET_CYCLES) ? HALF_PERIOD : RESET_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX) + 1;
  localparam logic [TMR_W-1:0] HP_LAST = TMR_W'(HALF_PERIOD - 1);
  localparam logic [TMR_W-1:0] RC_LAST = TMR_W'(RESET_CYCLES - 1);

  state_t             state, state_nx;
  logic [TMR_W-1:0]   tmr;
  logic               phase_last;
  logic [PULSE_W-1:0] np_q;
  logic [COUNT_W-1:0] count_sync;
  logic               sample_en;
  logic [COUNT_W-1:0] sample_exp;
  logic [PULSE_W-1:0] sample_idx;
  logic               mismatch;

  // The macro count is asynchronous to clk; never look at it raw.
  sync2 #(.W(COUNT_W)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (count_in),
    .q     (count_sync)
  );

  // Last cycle of the current timed phase.
  always_comb begin
    phase_last = 1'b0;
    if (state == RESET)
      phase_last = (tmr == RC_LAST);
    else if (state == ZERO_CHK || state == HIGH || state == LOW)
      phase_last = (tmr == HP_LAST);
  end

  // Next-state logic for the run sequence.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (start) state_nx = RESET;
      RESET:    if (phase_last) state_nx = ZERO_CHK;
      ZERO_CHK: if (phase_last) state_nx = (np_q == '0) ? DONE : HIGH;
      HIGH:     if (phase_last) state_nx = LOW;
      LOW:      if (phase_last) state_nx = (pulses_sent == np_q) ? DONE : HIGH;
      DONE:     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // Sample point: end of the zero check (expect 0) or end of a high phase
  // (expect the pulse count mod 16). Sync latency is 2 cycles, so with
  // HALF_PERIOD >= 3 the count has settled by the last high cycle.
  always_comb begin
    sample_en  = phase_last && (state == ZERO_CHK || state == HIGH);
    sample_exp = (state == HIGH) ? pulses_sent[COUNT_W-1:0] : '0;
    sample_idx = (state == HIGH) ? pulses_sent : '0;
    mismatch   = sample_en && (count_sync != sample_exp);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Phase timer restarts on every state change and idles at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      tmr <= '0;
    else if (state_nx != state || state == IDLE)
      tmr <= '0;
    else
      tmr <= tmr + 1'b1;
  end

  // Macro clock/reset are decoded from the next state and registered so the
  // pins are glitch-free and line up exactly with the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      macro_clk     <= 1'b0;
      macro_reset_n <= 1'b0;
    end else begin
      macro_clk     <= (state_nx == HIGH);
      macro_reset_n <= (state_nx != RESET);
    end
  end

  // Run results: cleared at an accepted start, held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      np_q          <= '0;
      pulses_sent   <= '0;
      err_count     <= '0;
      err_flag      <= 1'b0;
      first_err_idx <= '0;
    end else if (state == IDLE && start) begin
      np_q          <= num_pulses;
      pulses_sent   <= '0;
      err_count     <= '0;
      err_flag      <= 1'b0;
      first_err_idx <= '0;
    end else begin
      if (state_nx == HIGH && state != HIGH)
        pulses_sent <= pulses_sent + 1'b1;
      if (mismatch) begin
        err_count <= sat_inc(err_count);
        err_flag  <= 1'b1;
        if (!err_flag)
          first_err_idx <= sample_idx;
      end
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_count_macro_checker.sv
// Scoreboard bench: behavioural counter macro, arithmetic reference model,
// and a done-triggered monitor comparing run results.
`timescale 1ns/1ps
module tb_count_macro_checker;

  localparam int HP = 4;
  localparam int RC = 8;
  localparam int M_IDEAL = 0;
  localparam int M_STUCK = 1;
  localparam int M_SKIP  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [15:0] num_pulses = '0;
  logic [3:0]  count_in;
  logic        macro_clk, macro_reset_n, busy, done, err_flag;
  logic [15:0] pulses_sent, first_err_idx;
  logic [7:0]  err_count;

  typedef struct {
    int pulses;
    int errs;
    int flag;
    int first;
    int cycles;
  } exp_t;

  exp_t sb_q[$];
  exp_t last_exp;
  int   n_tests = 0;
  int   n_fail = 0;
  int   done_seen = 0;
  int   runs_pushed = 0;
  int   busy_cnt = 0;
  bit   prev_done = 0;
  int   mode = M_IDEAL;
  logic [3:0] mcnt = '0;

  always #5 clk = ~clk;

  count_macro_checker #(.HALF_PERIOD(HP), .RESET_CYCLES(RC)) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .num_pulses    (num_pulses),
    .count_in      (count_in),
    .macro_clk     (macro_clk),
    .macro_reset_n (macro_reset_n),
    .busy          (busy),
    .done          (done),
    .pulses_sent   (pulses_sent),
    .err_count     (err_count),
    .err_flag      (err_flag),
    .first_err_idx (first_err_idx)
  );

  // Behavioural counter macro with selectable fault.
  always @(posedge macro_clk or negedge macro_reset_n) begin
    if (!macro_reset_n)
      mcnt <= (mode == M_STUCK) ? 4'd5 : 4'd0;
    else case (mode)
      M_STUCK: mcnt <= 4'd5;
      M_SKIP:  mcnt <= (mcnt == 4'd7) ? 4'd9 : mcnt + 4'd1;
      default: mcnt <= mcnt + 4'd1;
    endcase
  end
  assign count_in = mcnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int next_val(input int m, input int v);
    if (m == M_STUCK) return 5;
    if (m == M_SKIP && v == 7) return 9;
    return (v + 1) % 16;
  endfunction

  // Reference: walk samples 0..n, expected value k mod 16 vs macro value.
  function automatic exp_t predict(input int m, input int n);
    exp_t e;
    int   v;
    int   errs;
    bit   seen;
    errs = 0;
    seen = 0;
    e.first = 0;
    v = (m == M_STUCK) ? 5 : 0;
    for (int k = 0; k <= n; k++) begin
      if (k > 0) v = next_val(m, v);
      if (v != k % 16) begin
        errs++;
        if (!seen) begin
          seen = 1;
          e.first = k;
        end
      end
    end
    e.pulses = n;
    e.errs   = (errs > 255) ? 255 : errs;
    e.flag   = seen ? 1 : 0;
    e.cycles = 1 + RC + HP + 2 * HP * n + 1;
    return e;
  endfunction

  // Monitor: on each done pulse pop the expected result and compare.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt  = 0;
      prev_done = 0;
    end else begin
      if (prev_done) check("done_one_cycle", {31'd0, done}, 0);
      if (busy) busy_cnt++;
      if (done) begin
        exp_t e;
        done_seen++;
        if (sb_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check("pulses_sent",   {16'd0, pulses_sent},   e.pulses);
          check("err_count",     {24'd0, err_count},     e.errs);
          check("err_flag",      {31'd0, err_flag},      e.flag);
          check("first_err_idx", {16'd0, first_err_idx}, e.first);
          check("run_cycles",    busy_cnt + 1,           e.cycles);
        end
        busy_cnt = 0;
      end
      prev_done = done;
    end
  end

  task automatic run(input int m, input int n);
    exp_t e;
    int   cyc;
    @(negedge clk);
    mode = m;
    num_pulses = n[15:0];
    start = 1'b1;
    e = predict(m, n);
    sb_q.push_back(e);
    last_exp = e;
    runs_pushed++;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (busy && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    check("run_timeout", {31'd0, busy}, 0);
    // Results must hold in IDLE.
    repeat (5) @(negedge clk);
    check("hold_pulses",  {16'd0, pulses_sent},   last_exp.pulses);
    check("hold_errs",    {24'd0, err_count},     last_exp.errs);
    check("hold_flag",    {31'd0, err_flag},      last_exp.flag);
    check("hold_first",   {16'd0, first_err_idx}, last_exp.first);
    check("hold_mrst_n",  {31'd0, macro_reset_n}, 1);
    check("hold_mclk",    {31'd0, macro_clk},     0);
  endtask

  task automatic abort_run();
    int cyc;
    int seen_before;
    @(negedge clk);
    mode = M_IDEAL;
    num_pulses = 16'd20;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(pulses_sent == 16'd5 && macro_clk) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    // Start during HIGH must be ignored.
    start = 1'b1;
    @(negedge clk);
    cyc++;
    start = 1'b0;
    while (pulses_sent != 16'd10 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check("abort_p10_cycles", cyc, RC + HP + 2 * HP * 9);
    check("abort_busy_before", {31'd0, busy}, 1);
    seen_before = done_seen;
    rst_n = 1'b0;
    #1;
    check("abort_busy",     {31'd0, busy},          0);
    check("abort_done",     {31'd0, done},          0);
    check("abort_mclk",     {31'd0, macro_clk},     0);
    check("abort_mrst_n",   {31'd0, macro_reset_n}, 0);
    check("abort_pulses",   {16'd0, pulses_sent},   0);
    check("abort_errs",     {24'd0, err_count},     0);
    check("abort_flag",     {31'd0, err_flag},      0);
    check("abort_first",    {16'd0, first_err_idx}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_abort_idle",   {31'd0, busy},          0);
    check("post_abort_mrst_n", {31'd0, macro_reset_n}, 1);
    repeat (20) @(negedge clk);
    check("abort_no_done", done_seen, seen_before);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy",   {31'd0, busy},          0);
    check("rst_done",   {31'd0, done},          0);
    check("rst_mclk",   {31'd0, macro_clk},     0);
    check("rst_mrst_n", {31'd0, macro_reset_n}, 0);
    check("rst_pulses", {16'd0, pulses_sent},   0);
    check("rst_errs",   {24'd0, err_count},     0);
    check("rst_flag",   {31'd0, err_flag},      0);
    check("rst_first",  {16'd0, first_err_idx}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run(M_IDEAL, 20);
    run(M_STUCK, 3);
    run(M_SKIP, 16);
    run(M_IDEAL, 0);
    run(M_STUCK, 600);
    abort_run();
    for (int i = 0; i < 8; i++)
      run(int'($urandom_range(0, 2)), int'($urandom_range(0, 40)));

    repeat (5) @(negedge clk);
    check("sb_empty", sb_q.size(), 0);
    check("done_count", done_seen, runs_pushed);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
